// File: rtl/hi_lo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide controller.
// Holds the default operand width and the controller FSM state encoding.
package hi_lo_div_ctrl_pkg;

    localparam int unsigned DivWidth = 32;

    // Controller FSM states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/hi_lo_div_ctrl_iter_step.sv
// One step of a restoring divide. This block is purely combinational.
// It shifts {prem, quo} left by one bit and trial-subtracts the divisor.
// Ports:
//   prem_i  partial remainder (always below dvsr_i, or any value when dvsr_i == 0)
//   quo_i   dividend / quotient shift register
//   dvsr_i  divisor magnitude
//   prem_o  next partial remainder
//   quo_o   next quotient shift register; the new quotient bit enters at the LSB
module hi_lo_div_ctrl_iter_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] prem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] dvsr_i,
    output logic [Width-1:0] prem_o,
    output logic [Width-1:0] quo_o
);

    logic [Width:0] shifted;
    logic [Width:0] diff;
    logic           ge;

    always_comb begin
        // The shift needs one extra bit: prem can be up to dvsr-1, so 2*prem+1 can overflow Width.
        shifted = {prem_i, quo_i[Width-1]};
        ge      = (shifted >= {1'b0, dvsr_i});
        diff    = shifted - {1'b0, dvsr_i};
        prem_o  = ge ? diff[Width-1:0] : shifted[Width-1:0];
        quo_o   = {quo_i[Width-2:0], ge};
    end

endmodule

// File: rtl/hi_lo_div_ctrl.sv
// Sequencing controller for the multi-cycle DIV/DIVU unit behind HI/LO.
// It runs a Width-step restoring divide on operand magnitudes and then applies the sign fix.
// It holds quotient (LO) and remainder (HI) until EXE acknowledges them.
// Ports:
//   clk_i, rst_i          clock; asynchronous active-high reset
//   div_req_i             start request, sampled only in idle
//   div_signed_i          1 = DIV, 0 = DIVU
//   dividend_i/divisor_i  operands, sampled only on the accept cycle
//   div_ack_i             EXE consumed the result
//   div_cancel_i          flush; aborts any state, highest priority
//   div_busy_o            operation in progress or result held
//   div_ready_o           result valid
//   quotient_o            registered quotient output
//   remainder_o           registered remainder output
module hi_lo_div_ctrl
    import hi_lo_div_ctrl_pkg::*;
#(
    parameter int unsigned Width = DivWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_req_i,
    input  logic             div_signed_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    input  logic             div_ack_i,
    input  logic             div_cancel_i,
    output logic             div_busy_o,
    output logic             div_ready_o,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] prem_q, prem_d;
    logic [Width-1:0] quo_q, quo_d;
    logic [Width-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             ready_q, ready_d;
    logic [Width-1:0] quotient_q, quotient_d;
    logic [Width-1:0] remainder_q, remainder_d;

    logic             a_neg, b_neg;
    logic [Width-1:0] a_mag, b_mag;
    logic [Width-1:0] step_prem, step_quo;

    hi_lo_div_ctrl_iter_step #(
        .Width (Width)
    ) u_step (
        .prem_i (prem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .prem_o (step_prem),
        .quo_o  (step_quo)
    );

    always_comb begin
        a_neg = div_signed_i & dividend_i[Width-1];
        b_neg = div_signed_i & divisor_i[Width-1];
        a_mag = a_neg ? -dividend_i : dividend_i;
        b_mag = b_neg ? -divisor_i : divisor_i;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        ready_d     = ready_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        if (div_cancel_i) begin
            state_d = StIdle;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (div_req_i) begin
                        state_d = StCalc;
                        cnt_d   = CntW'(Width - 1);
                        prem_d  = '0;
                        quo_d   = a_mag;
                        dvsr_d  = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                    end
                end
                StCalc: begin
                    prem_d = step_prem;
                    quo_d  = step_quo;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (!ready_q) begin
                        // The first DONE cycle registers the sign-fixed result.
                        // For divide by zero the step loop leaves prem = |dividend|.
                        // With r_neg = sign(dividend), the remainder then restores the original
                        // dividend, so only the quotient needs an override.
                        ready_d     = 1'b1;
                        quotient_d  = (dvsr_q == '0) ? '1 : (q_neg_q ? -quo_q : quo_q);
                        remainder_d = r_neg_q ? -prem_q : prem_q;
                    end else if (div_ack_i) begin
                        state_d = StIdle;
                        ready_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign div_busy_o  = (state_q != StIdle);
    assign div_ready_o = ready_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_hi_lo_div_ctrl.sv
// Scoreboard bench for hi_lo_div_ctrl (Width = 32).
// The driver pushes expected results as it issues requests.
// The monitor pops one expected result on each rising div_ready and compares it.
module tb_hi_lo_div_ctrl;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_req = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_ack = 1'b0;
    logic        div_cancel = 1'b0;
    logic        div_busy;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hi_lo_div_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .div_req_i    (div_req),
        .div_signed_i (div_signed),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .div_ack_i    (div_ack),
        .div_cancel_i (div_cancel),
        .div_busy_o   (div_busy),
        .div_ready_o  (div_ready),
        .quotient_o   (quotient),
        .remainder_o  (remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every rising edge of div_ready.
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (div_ready && !rdy_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'(div_ready), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("latency", 64'(cyc - e.acc), 64'd33);
            end
        end
        rdy_prev = div_ready;
    end

    // Call right after a negedge. Returns #1 after the accept edge with operands scrambled.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit push);
        div_req    = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        if (push) sb.push_back('{eq, er, cyc + 1});
        @(posedge clk);
        #1;
        div_req    = 1'b0;
        div_signed = 1'($urandom);
        dividend   = $urandom;
        divisor    = $urandom;
    endtask

    // Returns at the negedge where div_ready is first seen high.
    task automatic wait_ready();
        bit ok = 1'b0;
        bit busy_all = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (div_ready) begin
                ok = 1'b1;
                break;
            end
            if (!div_busy) busy_all = 1'b0;
        end
        check("ready_timeout", 64'(ok), 64'd1);
        check("busy_during_calc", 64'(busy_all), 64'd1);
    endtask

    task automatic do_ack();
        div_ack = 1'b1;
        @(posedge clk);
        #1;
        div_ack = 1'b0;
        check("ready_drop_after_ack", 64'(div_ready), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        bit seen;

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(div_busy), 64'd0);
        check("reset_ready", 64'(div_ready), 64'd0);
        check("reset_q", 64'(quotient), 64'd0);
        check("reset_r", 64'(remainder), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 7/2
        issue(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b1);
        wait_ready();
        do_ack();

        // DIV -7/2, then hold the result in DONE for 5 cycles
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        wait_ready();
        repeat (5) @(negedge clk);
        check("hold_ready", 64'(div_ready), 64'd1);
        check("hold_q", 64'(quotient), 64'hFFFF_FFFD);
        check("hold_r", 64'(remainder), 64'hFFFF_FFFF);
        do_ack();

        // DIV 7/-2
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1);
        wait_ready();
        do_ack();

        // Signed overflow, then the same operands unsigned
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        wait_ready();
        do_ack();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
        wait_ready();
        do_ack();

        // Divide by zero
        issue(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        wait_ready();
        do_ack();

        // Cancel mid-CALC: the op never completes and the outputs keep the last result
        issue(1'b0, 32'd50, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        div_cancel = 1'b1;
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        check("cancel_to_idle", 64'(div_busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_ready) seen = 1'b1;
        end
        check("cancel_no_ready", 64'(seen), 64'd0);
        check("cancel_q_hold", 64'(quotient), 64'hFFFF_FFFF);
        check("cancel_r_hold", 64'(remainder), 64'hFFFF_FFF9);

        // Request together with cancel in IDLE is dropped
        div_req    = 1'b1;
        div_cancel = 1'b1;
        @(posedge clk);
        #1;
        div_req    = 1'b0;
        div_cancel = 1'b0;
        check("cancel_drops_req", 64'(div_busy), 64'd0);
        @(negedge clk);

        // DIVU 100/7, then ack together with a new request
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        wait_ready();
        div_ack    = 1'b1;
        div_req    = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd9;
        divisor    = 32'd4;
        sb.push_back('{32'd2, 32'd1, cyc + 2});
        @(posedge clk);
        #1;
        div_ack = 1'b0;
        check("req_ignored_on_ack", 64'(div_busy), 64'd0);
        @(posedge clk);
        #1;
        div_req  = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("req_taken_next", 64'(div_busy), 64'd1);
        wait_ready();
        do_ack();

        // Asynchronous reset mid-CALC
        issue(1'b0, 32'd1000, 32'd10, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(div_busy), 64'd0);
        check("async_rst_ready", 64'(div_ready), 64'd0);
        check("async_rst_q", 64'(quotient), 64'd0);
        check("async_rst_r", 64'(remainder), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Sanity after reset
        issue(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b1);
        wait_ready();
        do_ack();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
